// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//
// Decodes a select index into a one-hot output. The index either comes
// directly from a load (DIRECT) or walks through every output automatically,
// dwelling div+1 cycles on each one (SCAN). While the block is idle or
// disabled the output is all-zero.
//
// Parameters
//   SEL_W  select width (1..6); the output has 2**SEL_W bits
//   DIV_W  width of the scan dwell divider
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       block enable; low sends the block to IDLE (out all-zero)
//   mode     0 = direct decode, 1 = auto-scan
//   sel_in   index to load
//   load     load request; accepted when load && ready
//   ready    high in IDLE and DIRECT, low in SCAN
//   div      scan dwell per output, in cycles minus one
//   out      one-hot 1 << cur_sel, or all-zero in IDLE
//   cur_sel  current index register
//   wrap     one-cycle pulse after the scan index wraps from max to 0
// -----------------------------------------------------------------------------
module decoder_scan #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  load,
    output logic                  ready,
    input  logic [DIV_W-1:0]      div,
    output logic [(1<<SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);

    localparam int N_OUT = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [DIV_W-1:0] tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             load_acc;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        tick_d    = tick_q;
        wrap_d    = 1'b0;

        // Loads are honoured in IDLE and DIRECT, including the cycle in which
        // en falls; later assignments below may still override cur_sel_d.
        load_acc = load && (state_q != SCAN);
        if (load_acc) begin
            cur_sel_d = sel_in;
        end

        case (state_q)
            IDLE: begin
                if (en) begin
                    if (mode) begin
                        state_d   = SCAN;
                        cur_sel_d = sel_in;
                        tick_d    = '0;
                    end else begin
                        state_d = DIRECT;
                    end
                end
            end

            DIRECT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (mode) begin
                    state_d = SCAN;
                    tick_d  = '0;
                end
            end

            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!mode) begin
                    state_d = DIRECT;
                end else if (tick_q >= div) begin
                    // >= rather than == so a div lowered mid-dwell below the
                    // current tick advances at once instead of overflowing.
                    tick_d    = '0;
                    cur_sel_d = cur_sel_q + SEL_W'(1);
                    wrap_d    = (cur_sel_q == {SEL_W{1'b1}});
                end else begin
                    tick_d = tick_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            tick_q    <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registers only, no input-to-output path
    // -------------------------------------------------------------------------
    assign out     = (state_q != IDLE) ? (N_OUT'(1) << cur_sel_q) : '0;
    assign ready   = (state_q != SCAN);
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width, with 2**SEL_W one-hot outputs (legal range 1..6).
REQ-002 SHALL have parameter DIV_W, default 8: width of the scan-rate divider.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1 bit: block enable; low forces outputs to zero.
REQ-006 SHALL have port mode, input, 1 bit: 0 = direct decode, 1 = auto-scan.
REQ-007 SHALL have port sel_in, input, SEL_W bits: select value to load.
REQ-008 SHALL have port load, input, 1 bit: load request for sel_in (valid).
REQ-009 SHALL have port ready, output, 1 bit: load is accepted this cycle when load && ready.
REQ-010 SHALL have port div, input, DIV_W bits: dwell time per output in scan mode, equal to div+1 cycles.
REQ-011 SHALL have port out, output, 2**SEL_W bits: one-hot decoded output, or all-zero.
REQ-012 SHALL have port cur_sel, output, SEL_W bits: current index register.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse when the scan index wraps from max to 0.

Function
REQ-014 SHALL implement states IDLE, DIRECT and SCAN, held in a state register.
REQ-015 SHALL drive out as 1 << cur_sel when the state is not IDLE, and all-zero in IDLE, decoded from registers only with no combinational path from inputs.
REQ-016 SHALL drive ready = 1 in IDLE and DIRECT, and ready = 0 in SCAN; load in SCAN is ignored.
REQ-017 SHALL, on an accepted load, set cur_sel <= sel_in, with out reflecting it one cycle later if the next state is DIRECT.
REQ-018 SHALL use these transitions from IDLE: en=1 with mode=0 goes to DIRECT; en=1 with mode=1 goes to SCAN, capturing cur_sel <= sel_in and clearing tick; en=0 stays in IDLE.
REQ-019 SHALL go from DIRECT or SCAN to IDLE when en=0, with out all-zero the next cycle and cur_sel retained.
REQ-020 SHALL go from DIRECT to SCAN when mode=1, keeping cur_sel and clearing tick, and from SCAN to DIRECT when mode=0, keeping cur_sel.
REQ-021 SHALL, in SCAN, increment tick each cycle; when tick >= div, clear tick and advance cur_sel by 1 modulo 2**SEL_W.
REQ-022 SHALL handle div=0 by advancing every cycle, and a div change mid-dwell by taking effect immediately through the >= compare.
REQ-023 SHALL assert wrap for exactly the cycle after cur_sel changes from 2**SEL_W-1 to 0 in SCAN; wrap is never asserted on a load or mode change.
REQ-024 SHALL give en=0 priority over mode and load; a load accepted in the same cycle as en falling still updates cur_sel.
REQ-025 SHALL have tick of width DIV_W that never overflows, since it clears at the div limit.

Reset
REQ-026 SHALL, while rst_n=0, immediately force: state IDLE, cur_sel 0, tick 0, out 0, wrap 0, ready 1.
REQ-027 SHALL abort any scan or load in progress on reset asserted mid-operation, with no pulse on wrap.
REQ-028 SHALL leave the IDLE state only on the first rising clk edge after rst_n rises with en=1.

Verification
REQ-029 SHALL cover, at SEL_W=3: reset, then en=1, mode=0, load with sel_in=5 -> next cycle out=8'h20, cur_sel=5, ready=1.
REQ-030 SHALL cover: mode=1, div=2 from cur_sel=6 -> out 8'h40 for 3 cycles, then 8'h80 for 3 cycles, then 8'h01 with wrap=1 for exactly one cycle.
REQ-031 SHALL cover: in SCAN, load=1 with sel_in=3 -> ready=0, cur_sel unaffected, scan continues.
REQ-032 SHALL cover: en dropped during SCAN at cur_sel=4 -> out=0 next cycle; en=1 with mode=0 -> out=8'h10.
REQ-033 SHALL cover: rst_n pulsed low mid-scan between clock edges -> out=0, cur_sel=0 immediately, with no wrap pulse.
REQ-034 SHALL cover: div=0 in SCAN -> out advances every cycle, and wrap fires every 8 cycles.
